// File: rtl/arb_pkg.sv
// Shared types and helpers for grant consumers of the fixed-priority arbiter.
package arb_pkg;

    // Widest client vector any grant consumer supports.
    localparam int unsigned MAX_SIZE = 16;

    // Sequencer FSM: waiting for a grant, or running a granted burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } seq_state_e;

    // Width of a client index; a single-client system still gets one bit.
    function automatic int unsigned IDX_W(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic onehot_legal(input logic [MAX_SIZE-1:0] vec);
        return (vec != '0) && ((vec & (vec - 16'd1)) == '0);
    endfunction

endpackage

// File: rtl/arb_onehot_encoder.sv
// One-hot grant to binary client index, plus a flag telling whether the
// input really was one-hot. The index is meaningless when legal_o is low.
module arb_onehot_encoder
    import arb_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter int unsigned IW   = IDX_W(SIZE)
) (
    input  logic [SIZE-1:0] onehot_i,
    output logic [IW-1:0]   idx_o,
    output logic            legal_o
);

    // OR together the indices of all set bits; exact for a one-hot input.
    always_comb begin
        // NOTE: assign a default before the loop so every path drives idx_o and no latch is inferred.
        idx_o = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (onehot_i[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end

    // Legality check on the zero-extended vector.
    always_comb begin
        legal_o = onehot_legal(MAX_SIZE'(onehot_i));
    end

endmodule

// File: rtl/arb_grant_sequencer.sv
// Requester-side companion to the fixed-priority arbiter: registers the
// request vector, accepts one legal grant per burst, streams the owner's
// burst beat by beat on a valid/ready port, then retires it with a
// one-cycle done pulse.
module arb_grant_sequencer
    import arb_pkg::*;
#(
    parameter  int unsigned SIZE  = 8,
    parameter  int unsigned LEN_W = 4,
    localparam int unsigned IW    = IDX_W(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE-1:0]       req_valid,
    input  logic [SIZE*LEN_W-1:0] req_len,
    output logic [SIZE-1:0]       req_done,
    output logic [SIZE-1:0]       arb_requests,
    input  logic [SIZE-1:0]       arb_grants,
    input  logic                  arb_grant_valid,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic                  beat_last,
    output logic [IW-1:0]         owner_idx,
    output logic                  grant_error
);

    seq_state_e        state_q, state_d;
    logic [SIZE-1:0]   req_q, req_d;
    logic [SIZE-1:0]   done_q, done_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              err_q, err_d;

    logic [IW-1:0]     enc_idx;
    logic              enc_legal;
    logic              grant_in_set;
    logic              grant_ok;
    logic              grant_bad;
    logic              last_fire;
    logic [LEN_W-1:0]  grant_len;
    logic [SIZE-1:0]   owner_onehot;

    arb_onehot_encoder #(
        .SIZE (SIZE),
        .IW   (IW)
    ) u_grant_enc (
        .onehot_i (arb_grants),
        .idx_o    (enc_idx),
        .legal_o  (enc_legal)
    );

    // Grant qualification: only sampled in IDLE, must be one-hot and inside
    // the request vector the arbiter is currently seeing.
    always_comb begin
        grant_in_set = ((arb_grants & ~req_q) == '0);
        grant_ok     = (state_q == IDLE) && arb_grant_valid && enc_legal && grant_in_set;
        grant_bad    = (state_q == IDLE) && arb_grant_valid && !(enc_legal && grant_in_set);
        last_fire    = (state_q == BURST) && beat_ready && (cnt_q == '0);
    end

    // Length of the granted client, muxed directly by the one-hot grant.
    always_comb begin
        grant_len = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (arb_grants[i]) begin
                grant_len = grant_len | req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Current owner expanded back to one-hot for the done pulse.
    always_comb begin
        owner_onehot = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            owner_onehot[i] = (owner_q == IW'(i));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one legal grant opens a burst, the final handshake closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_ok)  state_d = BURST;
            BURST:   if (last_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: request register, beat counter, owner, done, error.
    always_comb begin
        req_d   = req_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        done_d  = '0;
        err_d   = err_q | grant_bad;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    req_d   = '0;
                    cnt_d   = grant_len;
                    owner_d = enc_idx;
                end else begin
                    // Mask the client just retired: its req_valid may still be
                    // high this cycle and must not win a stale re-grant.
                    req_d = req_valid & ~done_q;
                end
            end
            BURST: begin
                req_d = '0;
                if (beat_ready) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else begin
                        done_d = owner_onehot;
                    end
                end
            end
            default: begin
                req_d = '0;
            end
        endcase
    end

    // Datapath registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // Outputs: beat signals decode from state and counter.
    always_comb begin
        beat_valid   = (state_q == BURST);
        beat_last    = (state_q == BURST) && (cnt_q == '0);
        arb_requests = req_q;
        req_done     = done_q;
        owner_idx    = owner_q;
        grant_error  = err_q;
    end

endmodule

// File: tb/tb_arb_grant_sequencer.sv
// Scoreboard bench for arb_grant_sequencer with a behavioural lowest-index
// arbiter. Each request round is turned into the expected burst order
// (ascending client index, len+1 beats each, one done per burst); a
// separate monitor pops and compares on every handshake and done pulse.
module tb_arb_grant_sequencer;

    localparam int unsigned SIZE  = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned IW    = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [SIZE-1:0]       req_valid = '0;
    logic [SIZE*LEN_W-1:0] req_len = '0;
    logic [SIZE-1:0]       req_done;
    logic [SIZE-1:0]       arb_requests;
    logic [SIZE-1:0]       arb_grants;
    logic                  arb_grant_valid;
    logic                  beat_valid;
    logic                  beat_ready = 1'b1;
    logic                  beat_last;
    logic [IW-1:0]         owner_idx;
    logic                  grant_error;

    logic                  force_bad = 1'b0;
    logic [SIZE-1:0]       bad_grant = '0;

    arb_grant_sequencer #(.SIZE(SIZE), .LEN_W(LEN_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_len         (req_len),
        .req_done        (req_done),
        .arb_requests    (arb_requests),
        .arb_grants      (arb_grants),
        .arb_grant_valid (arb_grant_valid),
        .beat_valid      (beat_valid),
        .beat_ready      (beat_ready),
        .beat_last       (beat_last),
        .owner_idx       (owner_idx),
        .grant_error     (grant_error)
    );

    // Fixed-priority arbiter: lowest set request bit wins; can be overridden.
    assign arb_grant_valid = force_bad ? 1'b1 : (arb_requests != '0);
    assign arb_grants      = force_bad ? bad_grant : (arb_requests & (~arb_requests + SIZE'(1)));

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    beat_t           exp_beats[$];
    logic [SIZE-1:0] exp_done[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          valid_cycles = 0;
    int          last_end_cyc = -1;
    int          last_gap = -1;
    int unsigned rereq [SIZE];
    bit          rand_ready = 1'b0;
    bit          rdy_pat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every handshake and done pulse against the scoreboard.
    initial begin : monitor
        beat_t           e;
        bit              prev_valid = 1'b0;
        bit              prev_hs = 1'b0;
        logic [IW-1:0]   prev_owner = '0;
        bit              prev_last = 1'b0;
        logic [SIZE-1:0] prev_done = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid   = 1'b0;
                prev_hs      = 1'b0;
                prev_done    = '0;
                last_end_cyc = -1;
            end else begin
                if (prev_valid && !prev_hs) begin
                    check("valid_held", 32'(beat_valid), 1);
                    check("owner_held", 32'(owner_idx), 32'(prev_owner));
                    check("last_held", 32'(beat_last), 32'(prev_last));
                end
                if (prev_done != '0)
                    check("stale_mask", 32'(arb_requests & prev_done), 0);
                if (beat_valid && !prev_valid && last_end_cyc >= 0) begin
                    last_gap = cyc - last_end_cyc;
                    check("restart_gap_min", 32'(last_gap >= 3), 1);
                end
                if (beat_valid) valid_cycles++;
                if (beat_valid && beat_ready) begin
                    hs_count++;
                    if (exp_beats.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: owner %0d last %0d, expected no beat (cycle %0d)",
                                 owner_idx, beat_last, cyc);
                    end else begin
                        e = exp_beats.pop_front();
                        check("beat_owner", 32'(owner_idx), 32'(e.idx));
                        check("beat_last", 32'(beat_last), 32'(e.last));
                    end
                    if (beat_last) last_end_cyc = cyc;
                end
                if (req_done != '0) begin
                    check("done_cycle_req", 32'(arb_requests & req_done), 0);
                    if (exp_done.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: got 0x%0h, expected none (cycle %0d)", req_done, cyc);
                    end else begin
                        check("done_vec", 32'(req_done), 32'(exp_done.pop_front()));
                    end
                    check("done_latency", 32'(cyc - last_end_cyc), 1);
                end
                prev_valid = beat_valid;
                prev_hs    = beat_valid && beat_ready;
                prev_owner = owner_idx;
                prev_last  = beat_last;
                prev_done  = req_done;
            end
        end
    end

    // One clock of client behaviour: drop req_valid the cycle after done
    // (unless re-requesting), then choose beat_ready.
    task automatic step();
        logic [SIZE-1:0] d;
        @(negedge clk);
        d = req_done;
        @(posedge clk);
        #1;
        for (int i = 0; i < SIZE; i++) begin
            if (d[i]) begin
                if (rereq[i] > 0) rereq[i]--;
                else req_valid[i] = 1'b0;
            end
        end
        if (rdy_pat.size() != 0) begin
            if (beat_valid) beat_ready = rdy_pat.pop_front();
        end else begin
            beat_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic push_burst(input int idx, input int len);
        beat_t b;
        for (int k = 0; k <= len; k++) begin
            b.idx  = idx;
            b.last = (k == len);
            exp_beats.push_back(b);
        end
        exp_done.push_back(SIZE'(1) << idx);
    endtask

    // Reference model: all clients of the mask are pending together, so
    // they are served in ascending index order, each for len+1 beats.
    task automatic issue(input logic [SIZE-1:0] mask);
        for (int i = 0; i < SIZE; i++) begin
            if (mask[i]) push_burst(i, int'(req_len[i*LEN_W +: LEN_W]));
        end
        req_valid = req_valid | mask;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_beats.size() != 0 || exp_done.size() != 0 || req_valid != '0) && n < 3000) begin
            step();
            n++;
        end
        check("drain_complete", 32'(exp_beats.size() + exp_done.size()), 0);
        exp_beats.delete();
        exp_done.delete();
        req_valid = '0;
        repeat (3) step();
    endtask

    initial begin : stim
        logic [SIZE-1:0] mask;
        int h0, v0, n;

        #2 rst_n = 1'b0;
        #1;
        check("rst_arb_requests", 32'(arb_requests), 0);
        check("rst_req_done", 32'(req_done), 0);
        check("rst_beat_valid", 32'(beat_valid), 0);
        check("rst_beat_last", 32'(beat_last), 0);
        check("rst_owner_idx", 32'(owner_idx), 0);
        check("rst_grant_error", 32'(grant_error), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        step();
        check("idle_arb_requests", 32'(arb_requests), 0);
        check("idle_beat_valid", 32'(beat_valid), 0);

        // Single client 3, three beats, ready held high.
        req_len[3*LEN_W +: LEN_W] = LEN_W'(2);
        v0 = valid_cycles;
        issue(SIZE'(8'h08));
        step();
        check("t1_arb_requests", 32'(arb_requests), 'h08);
        step();
        check("t1_first_beat", 32'(beat_valid), 1);
        check("t1_owner", 32'(owner_idx), 3);
        drain();
        check("t1_valid_cycles", 32'(valid_cycles - v0), 3);

        // Clients 1 and 5 together: 1 wins, 5 follows after retirement.
        req_len[1*LEN_W +: LEN_W] = LEN_W'(0);
        req_len[5*LEN_W +: LEN_W] = LEN_W'(1);
        issue(SIZE'(8'h22));
        drain();
        check("t2_restart_gap", 32'(last_gap), 3);

        // Backpressure: four beats under a fixed ready pattern.
        req_len[6*LEN_W +: LEN_W] = LEN_W'(3);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        v0 = valid_cycles;
        h0 = hs_count;
        issue(SIZE'(8'h40));
        drain();
        check("t3_valid_cycles", 32'(valid_cycles - v0), 7);
        check("t3_handshakes", 32'(hs_count - h0), 4);

        // Illegal multi-hot grant, then a legal grant for the same client.
        req_len[2*LEN_W +: LEN_W] = LEN_W'(1);
        bad_grant = SIZE'(8'h06);
        force_bad = 1'b1;
        issue(SIZE'(8'h04));
        step();
        step();
        check("t4_grant_error", 32'(grant_error), 1);
        check("t4_no_beat", 32'(beat_valid), 0);
        force_bad = 1'b0;
        drain();
        check("t4_error_sticky", 32'(grant_error), 1);

        // Reset during beat 2 of 4; the held request is served again in full.
        req_len[4*LEN_W +: LEN_W] = LEN_W'(3);
        issue(SIZE'(8'h10));
        h0 = hs_count;
        n = 0;
        while (hs_count == h0 && n < 50) begin
            step();
            n++;
        end
        check("t5_reached_beat2", 32'(hs_count - h0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_beat_valid", 32'(beat_valid), 0);
        check("t5_rst_beat_last", 32'(beat_last), 0);
        check("t5_rst_owner", 32'(owner_idx), 0);
        check("t5_rst_arb_requests", 32'(arb_requests), 0);
        check("t5_rst_req_done", 32'(req_done), 0);
        check("t5_rst_grant_error", 32'(grant_error), 0);
        exp_beats.delete();
        exp_done.delete();
        push_burst(4, 3);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        drain();

        // Client 0 re-requests across its own done pulse.
        req_len[0*LEN_W +: LEN_W] = LEN_W'(1);
        rereq[0] = 1;
        issue(SIZE'(8'h01));
        push_burst(0, 1);
        drain();

        // Randomized rounds with random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            mask = SIZE'($urandom_range(1, (1 << SIZE) - 1));
            for (int i = 0; i < SIZE; i++) begin
                req_len[i*LEN_W +: LEN_W] = LEN_W'($urandom_range(0, 7));
            end
            issue(mask);
            drain();
        end
        check("final_grant_error", 32'(grant_error), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
